multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I-subset core.
- Sequences fetch, decode, execute, memory and writeback over several clocks, and drives the 2-bit ALU_OP consumed by the ALU control block.
- Also drives mux selects, register/PC/IR write enables and the memory request/ready handshake.
- Detects illegal opcodes and memory timeouts, and reports them as sticky faults.

---
 rtl/multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I-subset core.
// Optional perf counters (instret, cycles) under MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
   parameter int width_instruc = 32,
   parameter int MEM_TIMEOUT   = 15,
   parameter int TO_W          = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     run,
   input  logic [width_instruc-1:0] instruccion,
   input  logic                     zero,
   input  logic                     mem_ready,
   output logic [1:0]               ALU_OP,
   output logic                     alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic                     ir_write,
   output logic                     pc_write,
   output logic                     reg_write,
   output logic                     mem_to_reg,
   output logic                     illegal,
   output logic                     bus_error,
`ifdef MULTICYCLE_CTRL_PERF_EN
   output logic [31:0]              instret,
   output logic [31:0]              cycles,
`endif
   output logic                     busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_WB_ALU,
      S_MEM_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_FAULT
   } state_t;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_t          state;
   state_t          state_d;
   state_t          next_run;
   logic [TO_W-1:0] to_cnt;
   logic [6:0]      opcode;
   logic            is_mem;
   logic            timeout;
   logic            ill_set;
   logic            be_set;
   logic            unused_ok;

   assign opcode    = instruccion[6:0];
   assign unused_ok = ^instruccion[width_instruc-1:7];
   assign next_run  = run ? S_FETCH : S_IDLE;

   assign is_mem = (state == S_FETCH) ||
                   (state == S_MEM_RD) ||
                   (state == S_MEM_WR);

   // to_cnt holds the number of ready-less cycles already spent
   assign timeout = is_mem && !mem_ready && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt    <= '0;
         illegal   <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         if (state_d != state) begin
            to_cnt <= '0;
         end else if (is_mem && !mem_ready) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (ill_set) illegal <= 1'b1;
         if (be_set) bus_error <= 1'b1;
      end
   end

   always_comb begin
      state_d = state;
      ill_set = 1'b0;
      be_set  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
               be_set  = 1'b1;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               (opcode == OP_R): state_d = S_EXEC_R;
               (opcode == OP_I): state_d = S_EXEC_I;
               (opcode == OP_L),
               (opcode == OP_S): state_d = S_MEM_ADDR;
               (opcode == OP_B): state_d = S_BRANCH;
               default: begin
                  state_d = S_FAULT;
                  ill_set = 1'b1;
               end
            endcase
         end
         S_EXEC_R: state_d = S_WB_ALU;
         S_EXEC_I: state_d = S_WB_ALU;
         S_WB_ALU: state_d = next_run;
         S_MEM_ADDR: begin
            state_d = (opcode == OP_S) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            if (mem_ready) begin
               state_d = S_WB_MEM;
            end else if (timeout) begin
               state_d = S_FAULT;
               be_set  = 1'b1;
            end
         end
         S_WB_MEM: state_d = next_run;
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = next_run;
            end else if (timeout) begin
               state_d = S_FAULT;
               be_set  = 1'b1;
            end
         end
         S_BRANCH: state_d = next_run;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ALU_OP     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      busy       = (state != S_IDLE) && (state != S_FAULT);
      unique case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            ALU_OP    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ALU_OP    = 2'b10;
         end
         S_WB_ALU: reg_write = 1'b1;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: mem_read = 1'b1;
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: mem_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            ALU_OP    = 2'b01;
            pc_write  = zero;
         end
         default: ;
      endcase
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic done;

   assign done = (state == S_WB_ALU) ||
                 (state == S_WB_MEM) ||
                 (state == S_BRANCH) ||
                 ((state == S_MEM_WR) && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= '0;
         cycles  <= '0;
      end else begin
         instret <= instret + 32'(done);
         cycles  <= cycles + 32'(busy);
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction model queues
// the expected per-cycle outputs, a negedge monitor compares them.
module tb_multicycle_ctrl;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [31:0] instruccion = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [1:0]  ALU_OP;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        pc_write;
   logic        reg_write;
   logic        mem_to_reg;
   logic        illegal;
   logic        bus_error;
   logic        busy;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] instret;
   logic [31:0] cycles;
`endif

   multicycle_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .instruccion (instruccion),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .ALU_OP      (ALU_OP),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .mem_to_reg  (mem_to_reg),
      .illegal     (illegal),
      .bus_error   (bus_error),
`ifdef MULTICYCLE_CTRL_PERF_EN
      .instret     (instret),
      .cycles      (cycles),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mr;
      logic        r;
      logic        z;
      logic [31:0] ins;
      logic [13:0] exp;
   } cyc_t;

   cyc_t        stim_q[$];
   logic [13:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        ill_m = 1'b0;
   logic        be_m = 1'b0;
   logic        last_run = 1'b0;
   logic [31:0] cur_ins = '0;
   int unsigned instret_m = 0;
   int unsigned cycles_m = 0;
   logic [13:0] obs;

   assign obs = {ALU_OP, alu_src_a, alu_src_b, mem_read, mem_write,
                 ir_write, pc_write, reg_write, mem_to_reg,
                 illegal, bus_error, busy};

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [13:0] e;
         e = exp_q.pop_front();
         check("cycle_outputs", 32'(obs), 32'(e));
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One expected cycle: inputs to drive and outputs required
   task automatic cyc(input logic mr, input logic r, input logic z,
                      input logic [1:0] op, input logic sa,
                      input logic [1:0] sb, input logic rd,
                      input logic wr, input logic irw, input logic pcw,
                      input logic rw, input logic m2r, input logic bsy);
      cyc_t c;
      c.mr  = mr;
      c.r   = r;
      c.z   = z;
      c.ins = cur_ins;
      c.exp = {op, sa, sb, rd, wr, irw, pcw, rw, m2r, ill_m, be_m, bsy};
      stim_q.push_back(c);
      last_run = r;
      if (bsy) cycles_m++;
   endtask

   task automatic idle(input logic r);
      cyc(rb(), r, rb(), 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic fault_cycles(input int n);
      repeat (n) cyc(rb(), rb(), rb(), 2'b00, 0, 2'b00,
                     0, 0, 0, 0, 0, 0, 0);
   endtask

   // kind 0=fetch 1=read 2=write; lat = cycle on which ready arrives
   task automatic mem_access(input int kind, input int lat,
                             output bit ok);
      int lim;
      lim = (lat > TMO) ? TMO : lat;
      for (int k = 1; k <= lim; k++) begin
         logic mr;
         mr = (k == lat);
         case (kind)
            0: cyc(mr, rb(), rb(), 2'b00, 0, 2'b01,
                   1, 0, mr, mr, 0, 0, 1);
            1: cyc(mr, rb(), rb(), 2'b00, 0, 2'b00,
                   1, 0, 0, 0, 0, 0, 1);
            default: cyc(mr, rb(), rb(), 2'b00, 0, 2'b00,
                         0, 1, 0, 0, 0, 0, 1);
         endcase
      end
      ok = (lat <= TMO);
      if (!ok) be_m = 1'b1;
   endtask

   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0000011: return 2;
         7'b0100011: return 3;
         7'b1100011: return 4;
         default:    return 5;
      endcase
   endfunction

   function automatic logic [31:0] make_ins(input int kind);
      logic [6:0]  op;
      logic [31:0] w;
      w = $urandom;
      case (kind)
         0: op = 7'b0110011;
         1: op = 7'b0010011;
         2: op = 7'b0000011;
         3: op = 7'b0100011;
         4: op = 7'b1100011;
         default: begin
            do op = 7'($urandom);
            while (kind_of(op) != 5);
         end
      endcase
      return {w[31:7], op};
   endfunction

   task automatic instr(input logic [31:0] ins, input int lf,
                        input int lm, input logic bz, output bit alive);
      bit ok;
      cur_ins = ins;
      alive = 1;
      mem_access(0, lf, ok);
      if (!ok) begin
         fault_cycles(3);
         alive = 0;
         return;
      end
      cyc(rb(), rb(), rb(), 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      case (kind_of(ins[6:0]))
         0, 1: begin
            cyc(rb(), rb(), rb(), 2'b10, 1,
                (kind_of(ins[6:0]) == 1) ? 2'b10 : 2'b00,
                0, 0, 0, 0, 0, 0, 1);
            cyc(rb(), rb(), rb(), 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
         end
         2, 3: begin
            cyc(rb(), rb(), rb(), 2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 1);
            mem_access((kind_of(ins[6:0]) == 2) ? 1 : 2, lm, ok);
            if (!ok) begin
               fault_cycles(3);
               alive = 0;
               return;
            end
            if (kind_of(ins[6:0]) == 2)
               cyc(rb(), rb(), rb(), 2'b00, 0, 2'b00,
                   0, 0, 0, 0, 1, 1, 1);
         end
         4: cyc(rb(), rb(), bz, 2'b01, 1, 2'b00, 0, 0, 0, bz, 0, 0, 1);
         default: begin
            ill_m = 1'b1;
            fault_cycles(3);
            alive = 0;
            return;
         end
      endcase
      instret_m++;
      if (!last_run) begin
         repeat ($urandom_range(0, 2)) idle(0);
         idle(1);
      end
   endtask

   task automatic drain(input bit tail);
      while (stim_q.size() > 0) begin
         cyc_t c;
         @(posedge clk);
         #1;
         c = stim_q.pop_front();
         mem_ready   = c.mr;
         zero        = c.z;
         run         = c.r;
         instruccion = c.ins;
         exp_q.push_back(c.exp);
      end
      if (tail) begin
         @(posedge clk);
         #1;
         run = 1'b0;
         mem_ready = 1'b0;
         @(negedge clk);
         #1;
         check("exp_q_drained", exp_q.size(), 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
         check("instret", instret, instret_m);
         check("cycles", cycles, cycles_m);
`endif
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("reset_outputs", 32'(obs), 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
      check("reset_instret", instret, 0);
      check("reset_cycles", cycles, 0);
`endif
      ill_m = 1'b0;
      be_m = 1'b0;
      instret_m = 0;
      cycles_m = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_after_reset", 32'(obs), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      bit ok;
      repeat (3) @(negedge clk);
      check("reset_state", 32'(obs), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      idle(1);
      instr(32'h00000033, 1, 1, 0, a);
      drain(1);
      do_reset();

      idle(1);
      instr(32'h00002003, 1, 3, 0, a);
      instr(32'h00000063, 1, 1, 1, a);
      instr(32'h00000063, 1, 1, 0, a);
      drain(1);
      do_reset();

      idle(1);
      instr(32'h0000007F, 1, 1, 0, a);
      drain(1);
      do_reset();

      idle(1);
      instr(32'h00000033, 16, 1, 0, a);
      drain(1);
      do_reset();

      idle(1);
      instr(32'h00000013, 15, 1, 0, a);
      instr(32'h00000023, 1, 15, 0, a);
      instr(32'h00002003, 1, 16, 0, a);
      drain(1);
      do_reset();

      // abort a load while its read request is outstanding
      cur_ins = 32'h00002003;
      idle(1);
      mem_access(0, 1, ok);
      cyc(rb(), 1, rb(), 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      cyc(rb(), 1, rb(), 2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, rb(), 2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, rb(), 2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 0, 1);
      drain(0);
      @(negedge clk);
      #1;
      check("pre_reset_mem_read", 32'(mem_read), 1);
      do_reset();
      stim_q.delete();

      for (int seg = 0; seg < 8; seg++) begin
         a = 1;
         idle(1);
         for (int i = 0; i < 25 && a; i++) begin
            int k;
            int lat[2];
            k = $urandom_range(0, 20);
            k = (k == 20) ? 5 : (k % 5);
            for (int j = 0; j < 2; j++) begin
               int r;
               r = $urandom_range(0, 39);
               if (r == 0) lat[j] = 16 + $urandom_range(0, 3);
               else if (r == 1) lat[j] = 15;
               else lat[j] = 1 + $urandom_range(0, 3);
            end
            instr(make_ins(k), lat[0], lat[1], rb(), a);
         end
         drain(1);
         do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
